// File: rtl/fifo_pkg.sv
// Shared definitions for the dual-clock FIFO: Gray-code helpers, pointer
// width convention and output buffer depth.
package fifo_pkg;

    // Widest pointer the helpers handle; callers zero-extend into this width
    // and cast the result back down to their own AW+1 bits.
    localparam int PTR_MAX_W = 16;

    // Entries in the read-side output buffer.
    localparam int OBUF_DEPTH = 2;

    typedef logic [PTR_MAX_W-1:0] ptr_max_t;

    // Pointers carry one extra bit over the address so that the MSB
    // tells a full lap apart from an empty FIFO.
    function automatic int ptr_width(input int aw);
        return aw + 1;
    endfunction

    function automatic ptr_max_t bin2gray(input ptr_max_t b);
        return b ^ (b >> 1);
    endfunction

    // Zero upper bits of a zero-extended Gray value decode to zero, so the
    // low bits of the result are the correct narrow binary value.
    function automatic ptr_max_t gray2bin(input ptr_max_t g);
        ptr_max_t b;
        b = g;
        for (int i = 1; i < PTR_MAX_W; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/fifo_rd_ctrl_if.sv
// Output stream of the FIFO read side: valid/ready handshake with data.
interface fifo_rd_ctrl_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;

    // Producer side (the read controller).
    modport master (
        output out_data,
        output out_valid,
        input  out_ready
    );

    // Consumer side.
    modport slave (
        input  out_data,
        input  out_valid,
        output out_ready
    );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a Gray-coded pointer crossing clock domains.
// Nothing sits between the stages so the first flop gets a full cycle to
// resolve metastability.
module sync_2ff #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] meta;

    // Shift the asynchronous input through two stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            // NOTE: non-blocking so q takes the old meta, giving two real stages.
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of the dual-clock FIFO. Synchronises the write
// pointer, generates the read pointer, empty flag and memory read requests,
// and streams popped words through a 2-entry output buffer that absorbs the
// one-cycle read latency of fifo_mem.
module fifo_rd_ctrl
    import fifo_pkg::*;
#(
    parameter  int WIDTH = 4,
    parameter  int DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             r_clk,
    input  logic             r_rst_n,
    input  logic [AW:0]      wptr_gray_async,
    output logic [AW:0]      rptr_gray,
    output logic [AW-1:0]    raddr,
    output logic             rd_rq,
    output logic             empty,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic [AW:0]      rd_level,
    fifo_rd_ctrl_if.master   ob
);

    localparam int PW = ptr_width(AW);

    logic [PW-1:0]    wq2;
    logic [PW-1:0]    wq2_bin;
    logic [PW-1:0]    rptr_bin;
    logic [PW-1:0]    rptr_bin_nxt;
    logic [PW-1:0]    rptr_gray_nxt;
    logic             inflight;
    logic             pop;
    logic [2:0]       pending;

    logic [WIDTH-1:0] buf_mem [OBUF_DEPTH];
    logic             buf_head;
    logic             buf_tail;
    logic [1:0]       buf_cnt;

    sync_2ff #(
        .W (PW)
    ) u_wptr_sync (
        .clk   (r_clk),
        .rst_n (r_rst_n),
        .d     (wptr_gray_async),
        .q     (wq2)
    );

    // Empty only on full-pointer equality; both operands are registers.
    assign empty = (rptr_gray == wq2);
    assign raddr = rptr_bin[AW-1:0];

    assign rptr_bin_nxt  = rptr_bin + PW'(1);
    assign rptr_gray_nxt = PW'(bin2gray(ptr_max_t'(rptr_bin_nxt)));

    // Occupancy seen from the read side; lags the writer, so never optimistic.
    assign wq2_bin  = PW'(gray2bin(ptr_max_t'(wq2)));
    assign rd_level = wq2_bin - rptr_bin;

    // Words already owed to the buffer after this cycle's pop. pop implies
    // buf_cnt >= 1, so the subtraction cannot underflow.
    assign pop     = ob.out_valid && ob.out_ready;
    assign pending = {1'b0, buf_cnt} + {2'b00, inflight} - {2'b00, pop};
    assign rd_rq   = !empty && (pending < 3'(OBUF_DEPTH));

    // Advance the read pointer on each issued request and remember that a
    // word will arrive from fifo_mem next cycle.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            rptr_bin  <= '0;
            rptr_gray <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= rd_rq;
            if (rd_rq) begin
                rptr_bin  <= rptr_bin_nxt;
                rptr_gray <= rptr_gray_nxt;
            end
        end
    end

    // Output buffer: capture returning words at the tail, pop from the head.
    always_ff @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n) begin
            // NOTE: the storage is reset too, because out_data must read 0
            // in reset and it is only two words wide.
            for (int i = 0; i < OBUF_DEPTH; i++) begin
                buf_mem[i] <= '0;
            end
            buf_head <= 1'b0;
            buf_tail <= 1'b0;
            buf_cnt  <= 2'd0;
        end else begin
            if (inflight) begin
                buf_mem[buf_tail] <= mem_rdata;
                buf_tail          <= ~buf_tail;
            end
            if (pop) begin
                buf_head <= ~buf_head;
            end
            // NOTE: the empty default holds buf_cnt; in a clocked block that
            // is a plain register enable, not a latch.
            case ({inflight, pop})
                2'b10:   buf_cnt <= buf_cnt + 2'd1;
                2'b01:   buf_cnt <= buf_cnt - 2'd1;
                default: ;
            endcase
        end
    end

    assign ob.out_data  = buf_mem[buf_head];
    assign ob.out_valid = (buf_cnt != 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a behavioural fifo_mem plus a write-side
// pointer model drive the controller; outputs are sampled 1 ns after the
// falling edge and compared against hand-computed values and a scoreboard.
module tb_fifo_rd_ctrl;

    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int AW    = 3;

    logic             r_clk = 1'b0;
    logic             r_rst_n;
    logic [AW:0]      wptr_gray_async;
    logic [AW:0]      rptr_gray;
    logic [AW-1:0]    raddr;
    logic             rd_rq;
    logic             empty;
    logic [WIDTH-1:0] mem_rdata;
    logic [AW:0]      rd_level;

    fifo_rd_ctrl_if #(.WIDTH(WIDTH)) ob_if ();

    fifo_rd_ctrl #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .r_clk           (r_clk),
        .r_rst_n         (r_rst_n),
        .wptr_gray_async (wptr_gray_async),
        .rptr_gray       (rptr_gray),
        .raddr           (raddr),
        .rd_rq           (rd_rq),
        .empty           (empty),
        .mem_rdata       (mem_rdata),
        .rd_level        (rd_level),
        .ob              (ob_if)
    );

    always #5 r_clk = ~r_clk;

    // Behavioural fifo_mem read port: registered, zero when not requested.
    logic [WIDTH-1:0] mem [DEPTH];
    always @(posedge r_clk or negedge r_rst_n) begin
        if (!r_rst_n)   mem_rdata <= '0;
        else if (rd_rq) mem_rdata <= mem[raddr];
        else            mem_rdata <= '0;
    end

    int               n_cmp = 0;
    int               n_bad = 0;
    logic [AW:0]      wr_bin;
    logic [AW:0]      iss;
    int               wr_cnt;
    int               pop_cnt;
    int               pulses;
    logic [WIDTH-1:0] sb [$];
    logic [WIDTH-1:0] exp_word;
    logic             hold_pending;
    logic [WIDTH-1:0] held;
    logic             ready;

    function automatic logic [AW:0] to_gray(input logic [AW:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance to 1 ns after the next falling edge(s).
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(negedge r_clk);
            #1;
        end
    endtask

    // Write one word on the write side and publish the new Gray pointer.
    task automatic push_word(input logic [WIDTH-1:0] d);
        mem[wr_bin[AW-1:0]] = d;
        sb.push_back(d);
        wr_bin          = wr_bin + 1'b1;
        wr_cnt++;
        wptr_gray_async = to_gray(wr_bin);
    endtask

    task automatic clear_write_side();
        wr_bin          = '0;
        wptr_gray_async = '0;
        wr_cnt          = 0;
        pop_cnt         = 0;
        iss             = '0;
        hold_pending    = 1'b0;
        held            = '0;
        sb.delete();
    endtask

    // One streaming cycle: check pointer and stability, pop against the
    // scoreboard, and write a new word if there is room and one is wanted.
    task automatic stream_step(input logic rdy, input logic want_wr, input int limit,
                               input logic [WIDTH-1:0] d);
        cyc();
        check("rptr_gray_seq", 32'(rptr_gray), 32'(to_gray(iss)));
        if (hold_pending) begin
            check("hold_valid", 32'(ob_if.out_valid), 32'd1);
            check("hold_data", 32'(ob_if.out_data), 32'(held));
        end
        ob_if.out_ready = rdy;
        #1;
        if (rd_rq) iss = iss + 1'b1;
        if (ob_if.out_valid && rdy) begin
            if (sb.size() == 0) begin
                check("pop_unexpected", 32'd1, 32'd0);
            end else begin
                exp_word = sb.pop_front();
                check("order", 32'(ob_if.out_data), 32'(exp_word));
            end
            pop_cnt++;
        end
        hold_pending = ob_if.out_valid && !rdy;
        held         = ob_if.out_data;
        if (want_wr && wr_cnt < limit && (wr_cnt - pop_cnt) < DEPTH) push_word(d);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        r_rst_n         = 1'b0;
        ob_if.out_ready = 1'b0;
        clear_write_side();

        // Reset values
        #1;
        check("rst_out_valid", 32'(ob_if.out_valid), 32'd0);
        check("rst_out_data", 32'(ob_if.out_data), 32'd0);
        check("rst_rd_rq", 32'(rd_rq), 32'd0);
        check("rst_empty", 32'(empty), 32'd1);
        check("rst_raddr", 32'(raddr), 32'd0);
        check("rst_rptr_gray", 32'(rptr_gray), 32'd0);
        check("rst_rd_level", 32'(rd_level), 32'd0);
        cyc(2);
        r_rst_n = 1'b1;

        // Latency: single word from empty with out_ready=1
        ob_if.out_ready = 1'b1;
        cyc();
        push_word(4'hA);
        cyc();
        check("lat_e1_empty", 32'(empty), 32'd1);
        cyc();
        check("lat_e2_empty", 32'(empty), 32'd0);
        check("lat_e2_rd_rq", 32'(rd_rq), 32'd1);
        check("lat_e2_rd_level", 32'(rd_level), 32'd1);
        check("lat_e2_raddr", 32'(raddr), 32'd0);
        cyc();
        check("lat_e3_empty", 32'(empty), 32'd1);
        check("lat_e3_rd_rq", 32'(rd_rq), 32'd0);
        check("lat_e3_out_valid", 32'(ob_if.out_valid), 32'd0);
        check("lat_e3_rptr_gray", 32'(rptr_gray), 32'd1);
        check("lat_e3_rd_level", 32'(rd_level), 32'd0);
        cyc();
        check("lat_e4_out_valid", 32'(ob_if.out_valid), 32'd1);
        check("lat_e4_out_data", 32'(ob_if.out_data), 32'hA);
        cyc();
        check("lat_e5_out_valid", 32'(ob_if.out_valid), 32'd0);

        // Back-pressure: 5 words with out_ready=0 -> only 2 reads issued
        ob_if.out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) push_word(WIDTH'(i));
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (rd_rq) pulses++;
        end
        check("bp_rd_rq_pulses", 32'(pulses), 32'd2);
        check("bp_out_valid", 32'(ob_if.out_valid), 32'd1);
        check("bp_head", 32'(ob_if.out_data), 32'd1);
        check("bp_rd_level", 32'(rd_level), 32'd3);
        check("bp_empty", 32'(empty), 32'd0);
        check("bp_rd_rq_idle", 32'(rd_rq), 32'd0);

        // Drain: one word per cycle, in order
        ob_if.out_ready = 1'b1;
        #1;
        check("drain_rd_rq", 32'(rd_rq), 32'd1);
        for (int i = 0; i < 5; i++) begin
            check("drain_valid", 32'(ob_if.out_valid), 32'd1);
            check("drain_data", 32'(ob_if.out_data), 32'(i + 1));
            cyc();
        end
        check("drain_end_valid", 32'(ob_if.out_valid), 32'd0);
        check("drain_end_empty", 32'(empty), 32'd1);
        check("drain_end_rd_level", 32'(rd_level), 32'd0);

        // Reset mid-stream with two words buffered
        ob_if.out_ready = 1'b0;
        push_word(4'h7);
        push_word(4'h8);
        push_word(4'h9);
        cyc(8);
        check("mid_pre_valid", 32'(ob_if.out_valid), 32'd1);
        check("mid_pre_head", 32'(ob_if.out_data), 32'h7);
        r_rst_n = 1'b0;
        clear_write_side();
        #1;
        check("mid_rst_out_valid", 32'(ob_if.out_valid), 32'd0);
        check("mid_rst_empty", 32'(empty), 32'd1);
        check("mid_rst_rd_rq", 32'(rd_rq), 32'd0);
        check("mid_rst_rptr_gray", 32'(rptr_gray), 32'd0);
        check("mid_rst_rd_level", 32'(rd_level), 32'd0);
        cyc(2);
        r_rst_n = 1'b1;
        cyc(3);
        check("post_rst_rd_rq", 32'(rd_rq), 32'd0);
        check("post_rst_empty", 32'(empty), 32'd1);
        check("post_rst_out_valid", 32'(ob_if.out_valid), 32'd0);

        // Wrap: stream 20 words with out_ready=1, pointer laps 15 -> 0
        for (int c = 0; c < 300 && pop_cnt < 20; c++) begin
            stream_step(1'b1, 1'b1, 20, WIDTH'(wr_cnt * 7 + 3));
        end
        check("wrap_popped", 32'(pop_cnt), 32'd20);
        cyc(2);
        check("wrap_rptr_gray", 32'(rptr_gray), 32'h6);
        check("wrap_empty", 32'(empty), 32'd1);
        check("wrap_out_valid", 32'(ob_if.out_valid), 32'd0);
        check("wrap_rd_level", 32'(rd_level), 32'd0);

        // Random out_ready and random single-step writes
        for (int c = 0; c < 600 && pop_cnt < 50; c++) begin
            ready = 1'($urandom_range(0, 1));
            stream_step(ready, 1'($urandom_range(0, 1)), 50, WIDTH'($urandom));
        end
        check("rand_popped", 32'(pop_cnt), 32'd50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
